// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU sequencer: opcodes, FSM encoding, widths.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_LW   = 4'b0000;
  localparam logic [3:0] OP_SW   = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } seq_state_t;

  // Opcodes 1100..1110 have no decoder meaning; they retire as NOPs.
  function automatic logic op_is_undef(input logic [3:0] op);
    return (op >= 4'b1100) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register: sequential increment or PC-relative branch
// with a 9-bit signed offset, wrapping modulo 2^PC_W.
module pc_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_i,
  input  logic            take_branch_i,
  input  logic [8:0]      offset_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d, off_ext;

  assign off_ext = PC_W'($signed(offset_i));

  // Next PC: pc+1, plus the sign-extended offset when the branch is taken.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (take_branch_i) pc_d = pc_d + off_ext;
  end

  // PC register, updated only when the sequencer retires an instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc_q <= RESET_PC;
    else if (ld_i) pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit lab CPU: fetch, decode, execute,
// optional data-memory access, writeback. Owns ir, PC and retired count.
// Optional single-step input enabled by defining CPU_SEQUENCER_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
`ifdef CPU_SEQUENCER_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               reg_write_in,
  input  logic               mem_write_in,
  input  logic               branch_cond,
  output logic               rf_we,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   retired,
  output logic               halted,
  output logic [2:0]         state
);

  seq_state_t          state_q, state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [CNT_W-1:0]    retired_q;
  logic [3:0]          opcode;
  logic                pc_ld, take_branch, go;

  assign opcode      = ir_q[15:12];
  assign take_branch = ((opcode == OP_BEQ) || (opcode == OP_BNE)) && branch_cond;

`ifdef CPU_SEQUENCER_STEP_EN
  assign go = run | step;
`else
  assign go = run;
`endif

  // Next-state and per-state strobes; strobes exist only in MEM/WRITEBACK.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_ld    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE:      if (go) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE:    state_d = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = ((opcode == OP_LW) || (opcode == OP_SW)) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write_in;
        if (dmem_ack) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_we   = reg_write_in & ~op_is_undef(opcode);
        pc_ld   = 1'b1;
        // A single step arrives with run=0, so it lands back in IDLE here.
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT:      halted = 1'b1;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Instruction register captures the fetched word only on a requested ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                ir_q <= '0;
    else if (state_q == S_FETCH && imem_ack) ir_q <= imem_rdata;
  end

  // Retired count advances once per completed (non-HALT) instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          retired_q <= '0;
    else if (state_q == S_WRITEBACK) retired_q <= retired_q + CNT_W'(1);
  end

  pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .rst           (rst),
    .ld_i          (pc_ld),
    .take_branch_i (take_branch),
    .offset_i      (ir_q[8:0]),
    .pc_o          (pc)
  );

  assign imem_addr = pc;
  assign ir        = ir_q;
  assign retired   = retired_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_WB = 3'd5, S_HALT = 3'd6;

  logic        clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr, imem_rdata = '0, ir, pc, retired;
  logic        reg_write_in = 1'b0, mem_write_in = 1'b0, branch_cond = 1'b0;
  logic        rf_we, dmem_req, dmem_we, dmem_ack = 1'b0, halted;
  logic [2:0]  state;
`ifdef CPU_SEQUENCER_STEP_EN
  logic        step = 1'b0;
`endif

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef CPU_SEQUENCER_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .branch_cond(branch_cond), .rf_we(rf_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .pc(pc),
    .retired(retired), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    bit          rw, mw, bc, drop, halt;
    int          iwait, dwait;
    logic [15:0] epc;
    int          ecyc, erfw, edreq, edwe;
  } vec_t;

  typedef struct {
    logic [15:0] epc, eret, eir;
    int          ecyc, erfw, edreq, edwe;
    logic [2:0]  estate;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  int   exp_ret = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] instr, input bit rw, mw, bc,
                              input int iwait, dwait, input bit drop, halt,
                              input logic [15:0] epc, input int ecyc, erfw, edreq, edwe);
    vec_t v;
    v.instr = instr; v.rw = rw; v.mw = mw; v.bc = bc; v.iwait = iwait;
    v.dwait = dwait; v.drop = drop; v.halt = halt; v.epc = epc;
    v.ecyc = ecyc; v.erfw = erfw; v.edreq = edreq; v.edwe = edwe;
    return v;
  endfunction

  // Drives one instruction through the DUT acting as imem/dmem/decoder,
  // then pops its expectation from the scoreboard and compares.
  task automatic run_instr(input vec_t v);
    exp_t e, g;
    int cyc = 0, rfw = 0, dreq = 0, dwe = 0, bad = 0, iw = 0, dw = 0;
    bit done = 0;
    if (!v.halt) exp_ret++;
    e.epc = v.epc; e.eret = 16'(exp_ret); e.eir = v.instr; e.ecyc = v.ecyc;
    e.erfw = v.erfw; e.edreq = v.edreq; e.edwe = v.edwe;
    e.estate = v.halt ? S_HALT : (v.drop ? S_IDLE : S_FETCH);
    sb.push_back(e);
    reg_write_in = v.rw; mem_write_in = v.mw; branch_cond = v.bc; run = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      imem_ack = 1'b0; dmem_ack = 1'b0;
      if (state != S_IDLE) cyc++;
      if (imem_req) begin
        if (imem_addr !== pc) bad++;
        if (iw == v.iwait) begin imem_ack = 1'b1; imem_rdata = v.instr; end
        else iw++;
      end
      if (dmem_req) begin
        dreq++;
        if (dmem_we) dwe++;
        if (dw == v.dwait) dmem_ack = 1'b1; else dw++;
      end
      if (dmem_we && !dmem_req) bad++;
      if (rf_we) begin rfw++; if (state != S_WB) bad++; end
      if (state == S_DECODE && v.drop) run = 1'b0;
      if (state == S_WB || state == S_HALT) done = 1;
    end
    @(posedge clk); #1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: instr %h never completed", v.instr);
    end
    g = sb.pop_front();
    chk($sformatf("pc[%h]", v.instr), pc, g.epc);
    chk($sformatf("retired[%h]", v.instr), retired, g.eret);
    chk($sformatf("ir[%h]", v.instr), ir, g.eir);
    chk($sformatf("state[%h]", v.instr), state, g.estate);
    chk($sformatf("cycles[%h]", v.instr), cyc, g.ecyc);
    chk($sformatf("rf_we_cnt[%h]", v.instr), rfw, g.erfw);
    chk($sformatf("dmem_req_cnt[%h]", v.instr), dreq, g.edreq);
    chk($sformatf("dmem_we_cnt[%h]", v.instr), dwe, g.edwe);
    chk($sformatf("strobe_misplaced[%h]", v.instr), bad, 0);
  endtask

  initial begin
    //            instr    rw mw bc iw dw drop halt epc   cyc rfw dreq dwe
    tbl.push_back(mk(16'h2123, 1, 0, 0, 0, 0, 0, 0, 16'h0001, 4, 1, 0, 0));
    tbl.push_back(mk(16'hC000, 1, 0, 0, 0, 0, 0, 0, 16'h0002, 4, 0, 0, 0));
    tbl.push_back(mk(16'h2456, 1, 0, 0, 2, 0, 0, 0, 16'h0003, 6, 1, 0, 0));
    tbl.push_back(mk(16'hA005, 0, 0, 1, 0, 0, 0, 0, 16'h0009, 4, 0, 0, 0));
    tbl.push_back(mk(16'hB1FB, 0, 0, 1, 0, 0, 0, 0, 16'h0005, 4, 0, 0, 0));
    tbl.push_back(mk(16'h0123, 1, 0, 0, 0, 3, 0, 0, 16'h0006, 8, 1, 4, 0));
    tbl.push_back(mk(16'h1234, 0, 1, 0, 0, 0, 0, 0, 16'h0007, 5, 0, 1, 1));
    tbl.push_back(mk(16'h1567, 0, 1, 0, 0, 2, 0, 0, 16'h0008, 7, 0, 3, 3));
    tbl.push_back(mk(16'hB0FF, 0, 0, 0, 0, 0, 0, 0, 16'h0009, 4, 0, 0, 0));
    tbl.push_back(mk(16'hA006, 0, 0, 1, 0, 0, 0, 0, 16'h0010, 4, 0, 0, 0));
    tbl.push_back(mk(16'hB1F8, 0, 0, 1, 0, 0, 0, 0, 16'h0009, 4, 0, 0, 0));
    tbl.push_back(mk(16'hA006, 0, 0, 1, 0, 0, 0, 0, 16'h0010, 4, 0, 0, 0));
    tbl.push_back(mk(16'hB1F8, 0, 0, 0, 0, 0, 0, 0, 16'h0011, 4, 0, 0, 0));
    tbl.push_back(mk(16'h3ABC, 1, 0, 0, 0, 0, 1, 0, 16'h0012, 4, 1, 0, 0));

    // Reset state.
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_state", state, S_IDLE);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_retired", retired, 16'h0000);
    chk("rst_strobes", {imem_req, rf_we, dmem_req, dmem_we, halted}, 5'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_hold_run0", state, S_IDLE);

    foreach (tbl[i]) run_instr(tbl[i]);

    // After run dropped mid-instruction the sequencer parks in IDLE.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_after_drop", {state, imem_req}, {S_IDLE, 1'b0});
    end

    // Reset while a fetch is outstanding drops the request immediately.
    run = 1'b1;
    @(negedge clk);
    chk("fetch_req_before_rst", {state, imem_req}, {S_FETCH, 1'b1});
    rst = 1'b1; #1;
    chk("rst_mid_fetch_req", imem_req, 1'b0);
    chk("rst_mid_fetch_state", state, S_IDLE);
    chk("rst_mid_fetch_pc", pc, 16'h0000);
    chk("rst_mid_fetch_retired", retired, 16'h0000);
    exp_ret = 0;
    @(negedge clk); rst = 1'b0;

    // Three NOPs to pc=3, then HALT with run held high.
    run_instr(mk(16'hC000, 0, 0, 0, 0, 0, 0, 0, 16'h0001, 4, 0, 0, 0));
    run_instr(mk(16'hD000, 1, 0, 0, 0, 0, 0, 0, 16'h0002, 4, 0, 0, 0));
    run_instr(mk(16'hE000, 0, 0, 0, 1, 0, 0, 0, 16'h0003, 5, 0, 0, 0));
    run_instr(mk(16'hF000, 1, 1, 0, 0, 0, 0, 1, 16'h0003, 3, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halt_quiet", {halted, state, imem_req, rf_we, dmem_req, dmem_we, pc, retired},
          {1'b1, S_HALT, 4'b0000, 16'h0003, 16'h0003});
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit lab CPU.
- Fetches each instruction over an instruction-memory handshake and holds it in the instruction register (ir) that drives the instruction decoder.
- Gates the decoder's RegWrite and MemWrite into single-phase strobes, sequences data-memory accesses, and owns the PC, including BEQ/BNE branch resolution.
- Sits between instruction memory, the decoder, the register file/ALU and data memory.

Parameters:
PC_W, 16, PC and imem address width (word-addressed)
RESET_PC, 16'h0000, PC value after reset
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
run  in  1  level; 1 = execute continuously
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  16  fetched instruction
ir  out  16  instruction register; feeds decoder fields (opcode ir[15:12], offset ir[8:0])
reg_write_in  in  1  decoder RegWrite
mem_write_in  in  1  decoder MemWrite
branch_cond  in  1  ALU compare result; 1 = branch condition true
rf_we  out  1  register-file write strobe
dmem_req  out  1  data-memory request
dmem_we  out  1  data-memory write qualifier
dmem_ack  in  1  data-memory access complete
pc  out  PC_W  current PC
retired  out  CNT_W  retired-instruction count
halted  out  1  1 in HALT state
state  out  3  encoded FSM state (debug)

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=0, retired=0, all strobes/requests=0, halted=0. Reset during an outstanding imem/dmem request drops the request in the same cycle.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- IDLE: run=1 -> FETCH.
- FETCH: imem_req=1 and imem_addr=pc every cycle until imem_ack. On the ack cycle ir<=imem_rdata -> DECODE. An ack in the first request cycle gives a 1-cycle FETCH. imem_ack while imem_req=0 is ignored.
- DECODE: 1 cycle; decoder and register-file reads settle. opcode 4'b1111 -> HALT; otherwise -> EXECUTE.
- EXECUTE: 1 cycle, ALU evaluates. Opcode 0000 (LW) or 0001 (SW) -> MEM; otherwise -> WRITEBACK.
- MEM: dmem_req=1 and dmem_we=mem_write_in, held until dmem_ack -> WRITEBACK.
- WRITEBACK: 1 cycle.
  - rf_we=reg_write_in.
  - pc update: if opcode is 1010 (BEQ) or 1011 (BNE) and branch_cond=1, pc <= pc+1+sext(ir[8:0]); else pc <= pc+1. Modulo 2^PC_W wrap.
  - retired <= retired+1 (wraps at 2^CNT_W).
  - Next state: FETCH if run=1, else IDLE.
- HALT: terminal; halted=1, no requests or strobes; exits only on rst. pc stays at the HALT address, retired not incremented.
- Undefined opcodes 1100–1110 execute as NOP: no rf_we/dmem, pc+1, counted.
- rf_we, dmem_req and dmem_we are never asserted outside WRITEBACK/MEM; at most one rf_we pulse per instruction.
- run deassert mid-instruction: the instruction completes, then IDLE.
- Latency with zero-wait memories: ALU/branch/NOP = 4 cycles, LW/SW = 5 cycles. Each wait cycle adds 1.

Optional Feature:
CPU_SEQUENCER_STEP_EN
- Defined: adds input step (1 bit). In IDLE, a step=1 pulse with run=0 executes exactly one instruction and returns to IDLE. step is ignored outside IDLE and when run=1.
- Undefined: no step port; IDLE leaves only on run=1.

Decomposition:
- cpu_pkg:
  - opcode constants OP_LW=4'b0000, OP_SW=4'b0001, OP_BEQ=4'b1010, OP_BNE=4'b1011, OP_HALT=4'b1111
  - seq_state_t enum (3-bit), encoding IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6
  - INSTR_W=16
- Sub-module pc_unit: holds the PC register and computes pc+1 or pc+1+sext(offset) from a load enable and a take_branch input.

Test Plan:
1. Reset then run=1, imem returns ADD (0x2xxx), imem_ack same cycle, reg_write_in=1 -> rf_we high exactly in cycle 4; pc 0->1; retired=1.
2. LW at pc=5 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we once after ack; pc=6; total 8 cycles.
3. BNE at pc=0x0010, offset 9'h1F8 (-8), branch_cond=1 -> pc=0x0009. Repeat with branch_cond=0 -> pc=0x0011. rf_we and dmem_req stay 0 in both.
4. SW with mem_write_in=1 -> dmem_we=1 only while dmem_req=1; rf_we never asserted.
5. Opcode 0xF000 at pc=3 -> halted=1 after DECODE; pc stays 3; retired unchanged; no imem_req with run held 1.
6. rst asserted mid-FETCH while imem_req=1 and imem_ack=0 -> imem_req=0 immediately; pc=RESET_PC; state=IDLE.
